// File: rtl/i2s_tx_if.sv
// Parallel sample-pair port of the I2S transmitter.
// Handshake: a {left_i, right_i} pair transfers on a rising clk edge where
// valid_i && ready_o. While ready_o is low the source must hold the pair.
interface i2s_tx_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] left_i;
  logic [WIDTH-1:0] right_i;
  logic             valid_i;
  logic             ready_o;

  modport master (
    output left_i,
    output right_i,
    output valid_i,
    input  ready_o
  );

  modport slave (
    input  left_i,
    input  right_i,
    input  valid_i,
    output ready_o
  );
endinterface

// File: rtl/i2s_tx.sv
// I2S master transmitter: buffers one left/right pair and serialises it
// MSB first in Philips format (WS leads each channel's MSB by one sclk).
module i2s_tx #(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 2
) (
  input  logic    clk_i,
  input  logic    rst_i,
  i2s_tx_if.slave smp_i,
  output logic    sclk_o,
  output logic    ws_o,
  output logic    sdata_o,
  output logic    underrun_o
);
  localparam int FW    = 2 * WIDTH;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FW);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FW - 1);
  localparam logic [BIT_W-1:0] WS_FIRST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0] WS_LAST  = BIT_W'(FW - 2);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             sclk_q, sclk_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [FW-1:0]    shift_q, shift_d;
  logic [FW-1:0]    buf_q, buf_d;
  logic             full_q, full_d;
  logic             armed_q, armed_d;
  logic             ws_q, ws_d;
  logic             sdata_q, sdata_d;
  logic             underrun_q, underrun_d;

  logic div_wrap;
  logic fall;
  logic load;
  logic accept;

  always_comb begin
    div_wrap = (div_cnt_q == DIV_LAST);
    fall     = div_wrap && sclk_q;
    load     = fall && (bit_cnt_q == BIT_LAST);
    accept   = smp_i.valid_i && !full_q;
  end

  always_comb begin
    div_cnt_d  = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
    sclk_d     = div_wrap ? ~sclk_q : sclk_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ws_d       = ws_q;
    sdata_d    = sdata_q;
    underrun_d = 1'b0;
    buf_d      = buf_q;
    full_d     = full_q;
    armed_d    = armed_q;

    // Serial state only moves on sclk falling edges so the DAC samples on rise.
    if (fall) begin
      bit_cnt_d = load ? '0 : bit_cnt_q + BIT_W'(1);
      if (load) begin
        shift_d    = full_q ? buf_q : '0;
        full_d     = 1'b0;
        underrun_d = !full_q && armed_q;
      end else begin
        shift_d = {shift_q[FW-2:0], 1'b0};
      end
      sdata_d = shift_d[FW-1];
      ws_d    = (bit_cnt_d >= WS_FIRST) && (bit_cnt_d <= WS_LAST);
    end

    // An accept coinciding with an empty-buffer load lands in the next frame.
    if (accept) begin
      buf_d   = {smp_i.left_i, smp_i.right_i};
      full_d  = 1'b1;
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt_q  <= '0;
      sclk_q     <= 1'b0;
      bit_cnt_q  <= BIT_LAST;
      shift_q    <= '0;
      buf_q      <= '0;
      full_q     <= 1'b0;
      armed_q    <= 1'b0;
      ws_q       <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      sclk_q     <= sclk_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      full_q     <= full_d;
      armed_q    <= armed_d;
      ws_q       <= ws_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
    end
  end

  assign smp_i.ready_o = ~full_q;
  assign sclk_o        = sclk_q;
  assign ws_o          = ws_q;
  assign sdata_o       = sdata_q;
  assign underrun_o    = underrun_q;
endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
I2S transmitter (serializer) for the audio-out path. It accepts parallel left/right sample pairs over a valid/ready handshake and buffers one pair. It generates sclk_o, ws_o and sdata_o as an I2S master (Philips format: MSB first, WS leads MSB by one sclk) for the downstream DAC. It is the transmit counterpart of the design's I2S receive front end.

Parameters:
WIDTH, 16, bits per channel sample (>=2).
CLK_DIV, 2, clk_i cycles per sclk half-period (>=1).

Ports:
clk_i  in  1  system clock; all logic on rising edge.
rst_i  in  1  synchronous, active-high reset.
left_i  in  WIDTH  left sample, captured on handshake.
right_i  in  WIDTH  right sample, captured on handshake.
valid_i  in  1  sample pair valid.
ready_o  out  1  holding buffer empty; pair accepted when valid_i && ready_o.
sclk_o  out  1  I2S bit clock, frequency clk_i/(2*CLK_DIV).
ws_o  out  1  word select; 0 = left, 1 = right.
sdata_o  out  1  serial data; changes only with sclk_o falling.
underrun_o  out  1  one-clk pulse when a frame starts with the buffer empty after arming.

Behaviour:
- Reset values (held while rst_i=1): sclk_o=0, ws_o=0, sdata_o=0, underrun_o=0, ready_o=1, div_cnt=0, bit_cnt=2*WIDTH-1, buffer empty, armed=0, shift register=0.
- Reset mid-frame aborts the frame immediately. Buffered data is discarded. No partial bits are resumed.
- Divider: div_cnt increments each clk. At div_cnt==CLK_DIV-1 it wraps to 0 and sclk_o toggles.
  - Rise at clk edge CLK_DIV after reset release; fall at edge 2*CLK_DIV; period 2*CLK_DIV.
- Fall event: the clk edge on which sclk_o goes 1->0. ws_o, sdata_o, bit_cnt and shift register update only on fall events. All outputs are registered.
- bit_cnt range 0..2*WIDTH-1. Each fall event: bit_cnt <= (bit_cnt==2*WIDTH-1) ? 0 : bit_cnt+1.
- Frame load, on the fall event where bit_cnt wraps to 0:
  - Buffer full: shift register <= {left,right}; buffer marked empty.
  - Buffer empty: shift register <= 0. If armed=1, underrun_o pulses for exactly that clk.
- sdata_o = shift register MSB for the new bit_cnt. Slots 0..WIDTH-1 carry left MSB..LSB; slots WIDTH..2*WIDTH-1 carry right MSB..LSB.
- ws_o = 1 when the new bit_cnt is in [WIDTH-1, 2*WIDTH-2], else 0. WS therefore changes together with each channel's LSB, one sclk before the next MSB.
- Handshake:
  - ready_o = buffer empty.
  - Accept on valid_i && ready_o: capture left_i/right_i, buffer full, armed <= 1.
  - ready_o is 0 from the following clk until the next frame load.
  - If accept and frame load occur on the same clk (buffer empty at load): the load uses zeros (underrun if armed) and the accepted pair enters the buffer for the next frame.
  - valid_i while ready_o=0 has no effect; the pair is not captured and the source must hold it.
- Before the first accept, frames transmit zeros with no underrun (armed=0).
- Latency: a pair accepted before the first fall event has its left MSB on sdata_o from edge 2*CLK_DIV. Otherwise it appears at the next frame boundary.
- Throughput: one pair per 2*WIDTH sclk periods. Continuous streaming requires one accept per frame.

Test Plan:
- Basic frame: WIDTH=16, CLK_DIV=2; accept left=16'hDEAD, right=16'hBEEF right after reset. Sample sdata_o on sclk_o rising edges -> 32 bits DEAD then BEEF MSB-first; ws_o=0 for the first 15 bits, 1 for bits 15..30, 0 at bit 31; underrun_o=0.
- Back-to-back: present CABB/FABB as soon as ready_o rises during frame 1 -> frame 2 carries CABB/FABB with no gap and no underrun; ready_o low from accept until the frame-2 load.
- Underrun: after one pair, stop valid_i -> next frame is all zeros and underrun_o is high for exactly one clk at the frame load; no underrun pulses before the first accept.
- Backpressure: hold valid_i=1 with changing data while ready_o=0 -> the buffer keeps the first captured pair; the transmitted frame matches it.
- Reset mid-frame: assert rst_i at bit 10 of the left word -> next clk sclk_o=0, ws_o=0, sdata_o=0, ready_o=1; after release, the first fall event is at edge 2*CLK_DIV and transmits a fresh frame.
- Divider sweep: CLK_DIV=1 and CLK_DIV=5 -> sclk_o period is 2 and 10 clks; sdata_o and ws_o change only on clk edges where sclk_o falls.
